// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-bus req/ready channel between the memory stage and the data memory
interface mem_access_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ready;
    logic [31:0] dbus_rdata;
    modport master (output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, input dbus_ready, dbus_rdata);
    modport slave (input dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, output dbus_ready, dbus_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 memory-stage bus controller with byte lanes, load extension, stall and fault/timeout
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemReqM,
    input  logic                      MemWriteM,
    input  logic [31:0]               ALUResultM,
    input  logic [31:0]               WriteDataM,
    input  logic [2:0]                funct3M,
    mem_access_stage_if.master        dbus,
    output logic [31:0]               ReadDataM,
    output logic                      StallM,
    output logic                      MemFaultM
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] cnt;
    logic        legal, aligned, ok, timeout;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, lane, load_data;
    always_comb begin
        legal = (funct3M[1:0] != 2'b11) && (!funct3M[2] || (!MemWriteM && funct3M[1:0] != 2'b10));
        aligned = funct3M[1] ? ALUResultM[1:0] == 2'b00 : funct3M[0] ? !ALUResultM[0] : 1'b1;
        ok = MemReqM && legal && aligned;
        be_n = funct3M[1] ? 4'b1111 : funct3M[0] ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALUResultM[1:0];
        wdata_n = funct3M[1] ? WriteDataM : funct3M[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
        lane = dbus.dbus_rdata >> {off_q, 3'b000};
        load_data = f3_q[1] ? lane :
                    f3_q[0] ? {{16{lane[15] & !f3_q[2]}}, lane[15:0]} : {{24{lane[7] & !f3_q[2]}}, lane[7:0]};
        // the counter would reach the limit at this edge unless ready arrives
        timeout = TIMEOUT_CYCLES > 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
        StallM = !rst && ((state == IDLE && ok) || state == BUSY);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_be    <= '0;
            dbus.dbus_wdata <= '0;
            ReadDataM       <= '0;
            MemFaultM       <= 1'b0;
            cnt             <= '0;
            f3_q            <= '0;
            off_q           <= '0;
        end else begin
            MemFaultM <= 1'b0;
            case (state)
                IDLE: begin
                    if (ok) begin
                        state           <= BUSY;
                        dbus.dbus_req   <= 1'b1;
                        dbus.dbus_we    <= MemWriteM;
                        dbus.dbus_addr  <= {ALUResultM[31:2], 2'b00};
                        dbus.dbus_be    <= be_n;
                        dbus.dbus_wdata <= wdata_n;
                        f3_q            <= funct3M;
                        off_q           <= ALUResultM[1:0];
                        cnt             <= '0;
                    end else if (MemReqM) begin
                        MemFaultM <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dbus.dbus_ready) begin
                        state         <= DONE;
                        dbus.dbus_req <= 1'b0;
                        ReadDataM     <= dbus.dbus_we ? '0 : load_data;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (timeout) begin
                            state         <= DONE;
                            dbus.dbus_req <= 1'b0;
                            ReadDataM     <= '0;
                            MemFaultM     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
